// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MCCPU: sequences the shared datapath through
// per-instruction states and handshakes with the unified memory port.
module mc_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       RegWrite,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       ALUSrc,
    output logic       ARegSel,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SLLV = 4'd11;
    localparam logic [3:0] ALU_SRLV = 4'd12;
    localparam logic [3:0] ALU_LUI  = 4'd13;

    localparam logic [7:0] TIMEOUT = ACK_TIMEOUT[7:0];

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       w_in_mem;
    logic       w_timeout;

    // Instruction class and EXEC-phase ALU controls, decoded from the held IR.
    logic       w_cls_alu, w_cls_mem, w_cls_br, w_cls_jmp;
    logic       w_jmp_reg, w_link;
    logic [3:0] w_dec_alu_op;
    logic       w_dec_alu_src, w_dec_areg_sel, w_dec_ext_op;

    logic       w_mem_req, w_iord, w_mem_write, w_ir_write, w_pc_write;
    logic [1:0] w_npc_op, w_gpr_sel, w_wd_sel;
    logic       w_reg_write, w_alu_src, w_areg_sel, w_ext_op;
    logic [3:0] w_alu_op;
    logic       w_illegal, w_bus_err;

    assign w_in_mem  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = (r_wait_cnt == TIMEOUT) && !mem_ack;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_in_mem && !mem_ack && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_cls_alu      = 1'b0;
        w_cls_mem      = 1'b0;
        w_cls_br       = 1'b0;
        w_cls_jmp      = 1'b0;
        w_jmp_reg      = 1'b0;
        w_link         = 1'b0;
        w_dec_alu_op   = 4'd0;
        w_dec_alu_src  = 1'b0;
        w_dec_areg_sel = 1'b0;
        w_dec_ext_op   = 1'b0;
        case (Op)
            OP_RTYPE: begin
                case (Funct)
                    F_ADD, F_ADDU: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_ADD;  end
                    F_SUB, F_SUBU: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SUB;  end
                    F_AND:         begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_AND;  end
                    F_OR:          begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_OR;   end
                    F_NOR:         begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_NOR;  end
                    F_SLT:         begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SLT;  end
                    F_SLTU:        begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SLTU; end
                    F_SLLV:        begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SLLV; end
                    F_SRLV:        begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SRLV; end
                    F_SLL: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SLL; w_dec_areg_sel = 1'b1; end
                    F_SRL: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SRL; w_dec_areg_sel = 1'b1; end
                    F_SRA: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SRA; w_dec_areg_sel = 1'b1; end
                    F_JR:   begin w_cls_jmp = 1'b1; w_jmp_reg = 1'b1; end
                    F_JALR: begin w_cls_jmp = 1'b1; w_jmp_reg = 1'b1; w_link = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_ADD; w_dec_alu_src = 1'b1; w_dec_ext_op = 1'b1; end
            OP_SLTI: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_SLT; w_dec_alu_src = 1'b1; w_dec_ext_op = 1'b1; end
            OP_ANDI: begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_AND; w_dec_alu_src = 1'b1; end
            OP_ORI:  begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_OR;  w_dec_alu_src = 1'b1; end
            OP_LUI:  begin w_cls_alu = 1'b1; w_dec_alu_op = ALU_LUI; w_dec_alu_src = 1'b1; end
            OP_LW, OP_SW:   w_cls_mem = 1'b1;
            OP_BEQ, OP_BNE: w_cls_br  = 1'b1;
            OP_J:    w_cls_jmp = 1'b1;
            OP_JAL:  begin w_cls_jmp = 1'b1; w_link = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_iord      = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_npc_op    = 2'b00;
        w_reg_write = 1'b0;
        w_gpr_sel   = 2'b00;
        w_wd_sel    = 2'b00;
        w_alu_src   = 1'b0;
        w_areg_sel  = 1'b0;
        w_ext_op    = 1'b0;
        w_alu_op    = 4'd0;
        w_illegal   = 1'b0;
        w_bus_err   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = !w_timeout;
                if (mem_ack) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_cls_alu)      w_next = S_EXEC;
                else if (w_cls_mem) w_next = S_MEMADR;
                else if (w_cls_br)  w_next = S_BRANCH;
                else if (w_cls_jmp) w_next = S_JUMP;
                else begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_EXEC, S_ALUWB: begin
                w_alu_op   = w_dec_alu_op;
                w_alu_src  = w_dec_alu_src;
                w_areg_sel = w_dec_areg_sel;
                w_ext_op   = w_dec_ext_op;
                if (r_state == S_EXEC) begin
                    w_next = S_ALUWB;
                end else begin
                    w_reg_write = 1'b1;
                    w_gpr_sel   = (Op == OP_RTYPE) ? 2'b00 : 2'b01;
                    w_next      = S_FETCH;
                end
            end
            S_MEMADR: begin
                w_alu_op  = ALU_ADD;
                w_alu_src = 1'b1;
                w_ext_op  = 1'b1;
                w_next    = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_req   = !w_timeout;
                w_mem_write = (r_state == S_MEMWR) && !w_timeout;
                if (mem_ack) begin
                    w_next = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (w_timeout) begin
                    w_bus_err = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                w_wd_sel    = 2'b01;
                w_gpr_sel   = 2'b01;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_op   = ALU_SUB;
                w_npc_op   = 2'b01;
                w_pc_write = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                w_npc_op   = w_jmp_reg ? 2'b11 : 2'b10;
                if (w_link) begin
                    w_reg_write = 1'b1;
                    w_wd_sel    = 2'b10;
                    w_gpr_sel   = 2'b10;
                end
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset forces every output low, so a write pending in the aborted state is never issued.
    assign mem_req  = !rst && w_mem_req;
    assign IorD     = !rst && w_iord;
    assign MemWrite = !rst && w_mem_write;
    assign IRWrite  = !rst && w_ir_write;
    assign PCWrite  = !rst && w_pc_write;
    assign NPCOp    = rst ? 2'b00 : w_npc_op;
    assign RegWrite = !rst && w_reg_write;
    assign GPRSel   = rst ? 2'b00 : w_gpr_sel;
    assign WDSel    = rst ? 2'b00 : w_wd_sel;
    assign ALUSrc   = !rst && w_alu_src;
    assign ARegSel  = !rst && w_areg_sel;
    assign EXTOp    = !rst && w_ext_op;
    assign ALUOp    = rst ? 4'd0 : w_alu_op;
    assign illegal  = !rst && w_illegal;
    assign bus_err  = !rst && w_bus_err;
    assign state    = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle vector table over whole instructions, plus
// hand-written sequences for delayed ack, ack timeout, illegal opcode and mid-write reset.
module tb_mc_ctrl;

    localparam int unsigned ACK_TIMEOUT = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_BAD  = 6'b111111;

    logic       clk, rst, Zero, mem_ack;
    logic [5:0] Op, Funct;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite;
    logic       ALUSrc, ARegSel, EXTOp, illegal, bus_err;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic [3:0] ALUOp, state;

    mc_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .NPCOp(NPCOp), .RegWrite(RegWrite), .GPRSel(GPRSel),
        .WDSel(WDSel), .ALUSrc(ALUSrc), .ARegSel(ARegSel), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {state,req,IorD,MemWrite,IRWrite,PCWrite,NPCOp,RegWrite,GPRSel,WDSel,ALUSrc,ARegSel,EXTOp,ALUOp,illegal,bus_err}
    logic [24:0] obs;
    assign obs = {state, mem_req, IorD, MemWrite, IRWrite, PCWrite, NPCOp, RegWrite,
                  GPRSel, WDSel, ALUSrc, ARegSel, EXTOp, ALUOp, illegal, bus_err};

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ack;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [24:0] x_fack, x_fwait, x_dec, x_madr, x_berr;

    function automatic logic [24:0] ex(input logic [3:0] st, input logic req, iord, mw, irw, pcw,
                                       input logic [1:0] npc, input logic rw,
                                       input logic [1:0] gs, wd, input logic as, ar, ext,
                                       input logic [3:0] alu, input logic ill, be);
        return {st, req, iord, mw, irw, pcw, npc, rw, gs, wd, as, ar, ext, alu, ill, be};
    endfunction

    function automatic void add(input logic r, input logic [5:0] op, fn,
                                input logic z, ack, input logic [24:0] exp);
        vec_t v;
        v.r = r; v.op = op; v.fn = fn; v.z = z; v.ack = ack; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [24:0] got, input logic [24:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle, advance past the edge.
    task automatic step(input logic r, input logic [5:0] op, fn, input logic z, ack,
                        input logic [24:0] exp, input string name);
        rst = r; Op = op; Funct = fn; Zero = z; mem_ack = ack;
        @(negedge clk);
        check(name, obs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        x_fack  = ex(0, 1,0,0,1,1, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0);
        x_fwait = ex(0, 1,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0);
        x_dec   = ex(1, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0);
        x_madr  = ex(4, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,1, 4'd1, 0,0);
        x_berr  = ex(0, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,1);

        // reset holds outputs low even with mem_ack high
        add(1, OP_R, F_ADD, 0, 1, 25'd0);
        add(1, OP_R, F_ADD, 0, 0, 25'd0);
        add(0, OP_R, F_ADD, 0, 0, x_fwait);
        // add
        add(0, OP_R, F_ADD, 0, 1, x_fack);
        add(0, OP_R, F_ADD, 0, 1, x_dec);
        add(0, OP_R, F_ADD, 0, 1, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd1, 0,0));
        add(0, OP_R, F_ADD, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 0,0,0, 4'd1, 0,0));
        // sub
        add(0, OP_R, F_SUB, 0, 1, x_fack);
        add(0, OP_R, F_SUB, 0, 0, x_dec);
        add(0, OP_R, F_SUB, 0, 0, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd2, 0,0));
        add(0, OP_R, F_SUB, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 0,0,0, 4'd2, 0,0));
        // sll: shamt on A
        add(0, OP_R, F_SLL, 0, 1, x_fack);
        add(0, OP_R, F_SLL, 0, 0, x_dec);
        add(0, OP_R, F_SLL, 0, 0, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,1,0, 4'd8, 0,0));
        add(0, OP_R, F_SLL, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 0,1,0, 4'd8, 0,0));
        // addi: sign-extended imm, rt
        add(0, OP_ADDI, 6'd5, 0, 1, x_fack);
        add(0, OP_ADDI, 6'd5, 0, 0, x_dec);
        add(0, OP_ADDI, 6'd5, 0, 0, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,1, 4'd1, 0,0));
        add(0, OP_ADDI, 6'd5, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b00, 1,0,1, 4'd1, 0,0));
        // ori: zero-extended imm
        add(0, OP_ORI, 6'd0, 0, 1, x_fack);
        add(0, OP_ORI, 6'd0, 0, 0, x_dec);
        add(0, OP_ORI, 6'd0, 0, 0, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,0, 4'd4, 0,0));
        add(0, OP_ORI, 6'd0, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b00, 1,0,0, 4'd4, 0,0));
        // slti
        add(0, OP_SLTI, 6'd0, 0, 1, x_fack);
        add(0, OP_SLTI, 6'd0, 0, 0, x_dec);
        add(0, OP_SLTI, 6'd0, 0, 0, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,1, 4'd5, 0,0));
        add(0, OP_SLTI, 6'd0, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b00, 1,0,1, 4'd5, 0,0));
        // lui
        add(0, OP_LUI, 6'd0, 0, 1, x_fack);
        add(0, OP_LUI, 6'd0, 0, 0, x_dec);
        add(0, OP_LUI, 6'd0, 0, 0, ex(2, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,0, 4'd13, 0,0));
        add(0, OP_LUI, 6'd0, 0, 0, ex(3, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b00, 1,0,0, 4'd13, 0,0));
        // lw, zero-wait
        add(0, OP_LW, 6'd0, 0, 1, x_fack);
        add(0, OP_LW, 6'd0, 0, 0, x_dec);
        add(0, OP_LW, 6'd0, 0, 0, x_madr);
        add(0, OP_LW, 6'd0, 0, 1, ex(5, 1,1,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0));
        add(0, OP_LW, 6'd0, 0, 0, ex(6, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b01, 0,0,0, 4'd0, 0,0));
        // sw, zero-wait
        add(0, OP_SW, 6'd0, 0, 1, x_fack);
        add(0, OP_SW, 6'd0, 0, 0, x_dec);
        add(0, OP_SW, 6'd0, 0, 0, x_madr);
        add(0, OP_SW, 6'd0, 0, 1, ex(7, 1,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0));
        // branches: all four Op/Zero combinations
        add(0, OP_BEQ, 6'd0, 1, 1, x_fack);
        add(0, OP_BEQ, 6'd0, 1, 0, x_dec);
        add(0, OP_BEQ, 6'd0, 1, 1, ex(8, 0,0,0,0,1, 2'b01, 0, 2'b00, 2'b00, 0,0,0, 4'd2, 0,0));
        add(0, OP_BEQ, 6'd0, 0, 1, x_fack);
        add(0, OP_BEQ, 6'd0, 0, 0, x_dec);
        add(0, OP_BEQ, 6'd0, 0, 0, ex(8, 0,0,0,0,0, 2'b01, 0, 2'b00, 2'b00, 0,0,0, 4'd2, 0,0));
        add(0, OP_BNE, 6'd0, 1, 1, x_fack);
        add(0, OP_BNE, 6'd0, 1, 0, x_dec);
        add(0, OP_BNE, 6'd0, 1, 0, ex(8, 0,0,0,0,0, 2'b01, 0, 2'b00, 2'b00, 0,0,0, 4'd2, 0,0));
        add(0, OP_BNE, 6'd0, 0, 1, x_fack);
        add(0, OP_BNE, 6'd0, 0, 0, x_dec);
        add(0, OP_BNE, 6'd0, 0, 0, ex(8, 0,0,0,0,1, 2'b01, 0, 2'b00, 2'b00, 0,0,0, 4'd2, 0,0));
        // jumps
        add(0, OP_JAL, 6'd0, 0, 1, x_fack);
        add(0, OP_JAL, 6'd0, 0, 0, x_dec);
        add(0, OP_JAL, 6'd0, 0, 0, ex(9, 0,0,0,0,1, 2'b10, 1, 2'b10, 2'b10, 0,0,0, 4'd0, 0,0));
        add(0, OP_J, 6'd0, 0, 1, x_fack);
        add(0, OP_J, 6'd0, 0, 0, x_dec);
        add(0, OP_J, 6'd0, 0, 0, ex(9, 0,0,0,0,1, 2'b10, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0));
        add(0, OP_R, F_JR, 0, 1, x_fack);
        add(0, OP_R, F_JR, 0, 0, x_dec);
        add(0, OP_R, F_JR, 0, 0, ex(9, 0,0,0,0,1, 2'b11, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0));
        add(0, OP_R, F_JALR, 0, 1, x_fack);
        add(0, OP_R, F_JALR, 0, 0, x_dec);
        add(0, OP_R, F_JALR, 0, 0, ex(9, 0,0,0,0,1, 2'b11, 1, 2'b10, 2'b10, 0,0,0, 4'd0, 0,0));
        // undecodable R-type funct
        add(0, OP_R, F_BAD, 0, 1, x_fack);
        add(0, OP_R, F_BAD, 0, 0, ex(1, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 1,0));
        add(0, OP_R, F_BAD, 0, 0, x_fwait);

        rst = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].ack, vecs[i].exp,
                 $sformatf("vec[%0d]", i));
        end

        // lw with mem_ack delayed 3 cycles in MEMRD
        step(0, OP_LW, 6'd0, 0, 1, x_fack, "lw_fetch");
        step(0, OP_LW, 6'd0, 0, 0, x_dec, "lw_decode");
        step(0, OP_LW, 6'd0, 0, 0, x_madr, "lw_memadr");
        for (int i = 0; i < 3; i++) begin
            step(0, OP_LW, 6'd0, 0, 0, ex(5, 1,1,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0),
                 $sformatf("lw_wait%0d", i));
        end
        step(0, OP_LW, 6'd0, 0, 1, ex(5, 1,1,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0), "lw_ack");
        step(0, OP_LW, 6'd0, 0, 0, ex(6, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b01, 0,0,0, 4'd0, 0,0), "lw_memwb");

        // fetch with no ack: 15 request cycles, then the bus_err cycle, then refetch
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            step(0, OP_ILL, 6'd0, 0, 0, x_fwait, $sformatf("to_wait%0d", i));
        end
        step(0, OP_ILL, 6'd0, 0, 0, x_berr, "to_bus_err");

        // refetch: ack arriving exactly on the limit cycle wins over the timeout
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            step(0, OP_ILL, 6'd0, 0, 0, x_fwait, $sformatf("refetch%0d", i));
        end
        step(0, OP_ILL, 6'd0, 0, 1, x_fack, "ack_at_limit");
        step(0, OP_ILL, 6'd0, 0, 0, ex(1, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 1,0), "illegal_op");

        // reset while a store is waiting in MEMWR
        step(0, OP_SW, 6'd0, 0, 1, x_fack, "sw_fetch");
        step(0, OP_SW, 6'd0, 0, 0, x_dec, "sw_decode");
        step(0, OP_SW, 6'd0, 0, 0, x_madr, "sw_memadr");
        step(0, OP_SW, 6'd0, 0, 0, ex(7, 1,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0, 4'd0, 0,0), "sw_wait");
        step(1, OP_SW, 6'd0, 0, 1, 25'd0, "rst_in_memwr");
        step(0, OP_SW, 6'd0, 0, 0, x_fwait, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
